// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC, bubble/NOP encodings,
// main-decoder opcode constants and the IF/ID pipeline bundle.
package core_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // The all-zero word decodes to all-zero controls, so it is a safe bubble.
  // NOP is the architectural addi x0,x0,0 and is distinct from a bubble.
  localparam logic [31:0] BUBBLE   = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // Main-decoder opcodes (InstrD[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   flush      : replace instruction with bubble (overrides stall)
//   stall      : hold the whole bundle
//   bubble     : no usable fetch this cycle (wait state or redirect)
//   d          : bundle presented by the fetch stage
//   q          : registered bundle for decode
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [31:0] BUBBLE_W = core_pkg::BUBBLE
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // ---- IF -> ID boundary ----
  // Flush and bubble keep the PC fields: only the instruction and its
  // valid flag are meaningful once a slot has been squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{instr: BUBBLE_W, pc: '0, pcplus4: '0, valid: 1'b0};
    end else if (flush) begin
      q.instr <= BUBBLE_W;
      q.valid <= 1'b0;
    end else if (!stall) begin
      if (bubble) begin
        q.instr <= BUBBLE_W;
        q.valid <= 1'b0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   StallF, StallD, FlushD: hazard-unit controls
//   PCSrcE, PCTargetE     : taken branch/jump redirect from Execute
//   imem_addr             : fetch address (= PCF)
//   imem_rdata, imem_valid: instruction word and its valid (low = wait)
//   InstrD, PCD, PCPlus4D, ValidD : decode-stage bundle
//   MisalignE             : one-cycle pulse after a misaligned redirect
module fetch_stage
  import core_pkg::*;
#(
  parameter int          XLEN     = core_pkg::XLEN,
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
  parameter logic [31:0] BUBBLE   = core_pkg::BUBBLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            MisalignE
);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pcplus4_p0;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_p1;
  logic            bubble_p0;
  if_id_t          load_p0;
  if_id_t          ifid_p1;

  assign imem_addr   = pc_p0;
  assign pcplus4_p0  = pc_p0 + XLEN'(4);
  assign redirect_pc = {PCTargetE[XLEN-1:2], 2'b00};

  // A redirect beats both stall and wait: whatever sits in D is wrong-path.
  always_comb begin
    pc_next = pcplus4_p0;
    if (PCSrcE) begin
      pc_next = redirect_pc;
    end else if (StallF || !imem_valid) begin
      pc_next = pc_p0;
    end
  end

  // ---- PC register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC[XLEN-1:0];
    end else begin
      pc_p0 <= pc_next;
    end
  end

  // ---- Misalign pulse, registered alongside the redirect ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_p1 <= 1'b0;
    end else begin
      misalign_p1 <= PCSrcE && (PCTargetE[1:0] != 2'b00);
    end
  end

  // The fetched word is unusable on a wait state, and wrong-path on redirect.
  assign bubble_p0 = !imem_valid || PCSrcE;
  assign load_p0   = '{instr: imem_rdata, pc: pc_p0, pcplus4: pcplus4_p0, valid: 1'b1};

  if_id_reg #(
    .BUBBLE_W (BUBBLE)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .flush  (FlushD),
    .stall  (StallD),
    .bubble (bubble_p0),
    .d      (load_p0),
    .q      (ifid_p1)
  );

  assign InstrD    = ifid_p1.instr;
  assign PCD       = ifid_p1.pc;
  assign PCPlus4D  = ifid_p1.pcplus4;
  assign ValidD    = ifid_p1.valid;
  assign MisalignE = misalign_p1;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE, imem_valid;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignE;
  logic [31:0] junk;
  int          mem_mode;

  int checks   = 0;
  int failures = 0;

  // Reference state, updated from the rules at each rising edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_vld, m_mis;

  always #5 clk = ~clk;

  // Instruction memory: constant NOP in mode 0, address-tagged words in mode 1.
  function automatic logic [31:0] word_at(input int mode, input logic [31:0] a);
    if (mode == 0) return 32'h0000_0013;
    return {a[15:0] ^ 16'hC0DE, a[15:0]} | 32'h3;
  endfunction

  assign imem_rdata = imem_valid ? word_at(mem_mode, imem_addr) : junk;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .MisalignE  (MisalignE)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0;
    m_vld = 1'b0; m_mis = 1'b0;
  endtask

  task automatic clear_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_valid = 1; junk = $urandom | 32'h8000_0000;
  endtask

  // One clock: apply the rules to the model at the edge, return at negedge.
  task automatic tick();
    logic [31:0] n_pc;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (PCSrcE)                   n_pc = PCTargetE & 32'hFFFF_FFFC;
      else if (StallF || !imem_valid) n_pc = m_pc;
      else                          n_pc = m_pc + 32'd4;
      if (FlushD) begin
        m_instr = 32'h0; m_vld = 1'b0;
      end else if (!StallD) begin
        if (!imem_valid || PCSrcE) begin
          m_instr = 32'h0; m_vld = 1'b0;
        end else begin
          m_instr = word_at(mem_mode, m_pc); m_pcd = m_pc;
          m_pc4 = m_pc + 32'd4; m_vld = 1'b1;
        end
      end
      m_mis = PCSrcE && (PCTargetE[1:0] != 2'b00);
      m_pc  = n_pc;
    end
    @(negedge clk);
    junk = $urandom | 32'h8000_0000;
  endtask

  task automatic test_reset();
    reset = 1; mem_mode = 0; clear_inputs(); model_reset();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", imem_addr, 32'h0); end
    checks++; if (InstrD !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%h expected=%h", InstrD, 32'h0); end
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin failures++; $display("FAIL reset_pcd actual=%h/%h expected=0/0", PCD, PCPlus4D); end
    checks++; if (ValidD !== 1'b0 || MisalignE !== 1'b0) begin failures++; $display("FAIL reset_flags actual=%b%b expected=00", ValidD, MisalignE); end
  endtask

  task automatic test_sequential();
    reset = 0;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL seq_start actual=%h expected=%h", imem_addr, 32'h0); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (imem_addr !== 32'(4*k)) begin failures++; $display("FAIL seq_pc k=%0d actual=%h expected=%h", k, imem_addr, 32'(4*k)); end
      checks++; if (InstrD !== 32'h13 || ValidD !== 1'b1) begin failures++; $display("FAIL seq_instr k=%0d actual=%h/%b expected=00000013/1", k, InstrD, ValidD); end
      checks++; if (PCD !== 32'(4*(k-1)) || PCPlus4D !== 32'(4*k)) begin failures++; $display("FAIL seq_pcd k=%0d actual=%h/%h expected=%h/%h", k, PCD, PCPlus4D, 32'(4*(k-1)), 32'(4*k)); end
    end
  endtask

  task automatic test_redirect();
    mem_mode = 1;
    PCSrcE = 1; PCTargetE = 32'h40;
    tick();
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL redir_pc actual=%h expected=%h", imem_addr, 32'h40); end
    checks++; if (InstrD !== 32'h0 || ValidD !== 1'b0 || MisalignE !== 1'b0) begin failures++; $display("FAIL redir_bubble actual=%h/%b/%b expected=0/0/0", InstrD, ValidD, MisalignE); end
    PCSrcE = 0;
    tick();
    checks++; if (InstrD !== word_at(1, 32'h40) || ValidD !== 1'b1) begin failures++; $display("FAIL redir_load actual=%h/%b expected=%h/1", InstrD, ValidD, word_at(1, 32'h40)); end
    checks++; if (PCD !== 32'h40 || PCPlus4D !== 32'h44 || imem_addr !== 32'h44) begin failures++; $display("FAIL redir_pcd actual=%h/%h/%h expected=40/44/44", PCD, PCPlus4D, imem_addr); end
  endtask

  task automatic test_stall();
    PCSrcE = 1; PCTargetE = 32'h4; tick();
    PCSrcE = 0; tick();
    StallF = 1; StallD = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stall_pc k=%0d actual=%h expected=%h", k, imem_addr, 32'h8); end
      checks++; if (InstrD !== word_at(1, 32'h4) || PCD !== 32'h4 || ValidD !== 1'b1) begin failures++; $display("FAIL stall_d k=%0d actual=%h/%h expected=%h/4", k, InstrD, PCD, word_at(1, 32'h4)); end
    end
    StallF = 0; StallD = 0;
    tick();
    checks++; if (imem_addr !== 32'hC || InstrD !== word_at(1, 32'h8) || PCD !== 32'h8) begin failures++; $display("FAIL stall_release actual=%h/%h/%h expected=c/%h/8", imem_addr, InstrD, PCD, word_at(1, 32'h8)); end
  endtask

  task automatic test_wait();
    PCSrcE = 1; PCTargetE = 32'h20; tick();
    PCSrcE = 0; imem_valid = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL wait_pc k=%0d actual=%h expected=%h", k, imem_addr, 32'h20); end
      checks++; if (InstrD !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL wait_bubble k=%0d actual=%h/%b expected=0/0", k, InstrD, ValidD); end
    end
    imem_valid = 1;
    tick();
    checks++; if (InstrD !== word_at(1, 32'h20) || PCD !== 32'h20 || ValidD !== 1'b1 || imem_addr !== 32'h24) begin failures++; $display("FAIL wait_load actual=%h/%h/%b/%h expected=%h/20/1/24", InstrD, PCD, ValidD, imem_addr, word_at(1, 32'h20)); end
  endtask

  task automatic test_flush_combo();
    FlushD = 1; StallD = 1; PCSrcE = 1; PCTargetE = 32'h102;
    tick();
    checks++; if (InstrD !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL combo_bubble actual=%h/%b expected=0/0", InstrD, ValidD); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL combo_pc actual=%h expected=%h", imem_addr, 32'h100); end
    checks++; if (MisalignE !== 1'b1) begin failures++; $display("FAIL combo_misalign actual=%b expected=1", MisalignE); end
    checks++; if (PCD !== 32'h20) begin failures++; $display("FAIL combo_pcd_hold actual=%h expected=%h", PCD, 32'h20); end
    clear_inputs();
    tick();
    checks++; if (MisalignE !== 1'b0) begin failures++; $display("FAIL combo_pulse actual=%b expected=0", MisalignE); end
    checks++; if (InstrD !== word_at(1, 32'h100) || imem_addr !== 32'h104) begin failures++; $display("FAIL combo_resume actual=%h/%h expected=%h/104", InstrD, imem_addr, word_at(1, 32'h100)); end
  endtask

  task automatic test_wrap();
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC; tick();
    PCSrcE = 0; tick();
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_pc actual=%h expected=%h", imem_addr, 32'h0); end
    checks++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin failures++; $display("FAIL wrap_pcd actual=%h/%h expected=fffffffc/0", PCD, PCPlus4D); end
  endtask

  task automatic test_async_reset();
    PCSrcE = 1; PCTargetE = 32'h44; tick();
    PCSrcE = 0; tick();
    checks++; if (imem_addr !== 32'h48 || ValidD !== 1'b1) begin failures++; $display("FAIL areset_setup actual=%h/%b expected=48/1", imem_addr, ValidD); end
    StallF = 1; StallD = 1;
    @(posedge clk); #2;
    reset = 1;
    #1;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL areset_pc actual=%h expected=%h", imem_addr, 32'h0); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCD !== 32'h0) begin failures++; $display("FAIL areset_d actual=%b/%h/%h expected=0/0/0", ValidD, InstrD, PCD); end
    model_reset();
    @(negedge clk);
    reset = 0; clear_inputs();
    tick();
    checks++; if (InstrD !== word_at(1, 32'h0) || PCD !== 32'h0 || imem_addr !== 32'h4) begin failures++; $display("FAIL areset_first actual=%h/%h/%h expected=%h/0/4", InstrD, PCD, imem_addr, word_at(1, 32'h0)); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      StallF     = ($urandom % 4) == 0;
      StallD     = ($urandom % 4) == 0;
      FlushD     = ($urandom % 8) == 0;
      PCSrcE     = ($urandom % 6) == 0;
      PCTargetE  = (($urandom % 8) == 0) ? (32'hFFFF_FFF8 | ($urandom % 8)) : ($urandom & 32'hFFF);
      imem_valid = ($urandom % 5) != 0;
      tick();
      checks++;
      if (imem_addr !== m_pc || InstrD !== m_instr || PCD !== m_pcd ||
          PCPlus4D !== m_pc4 || ValidD !== m_vld || MisalignE !== m_mis) begin
        failures++;
        if (errs < 10)
          $display("FAIL random i=%0d actual pc=%h ins=%h pcd=%h p4=%h v=%b m=%b required pc=%h ins=%h pcd=%h p4=%h v=%b m=%b",
                   i, imem_addr, InstrD, PCD, PCPlus4D, ValidD, MisalignE,
                   m_pc, m_instr, m_pcd, m_pc4, m_vld, m_mis);
        errs++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_wait();
    test_flush_combo();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
